// File: rtl/rd_monitor.sv
// Running-disparity tracker and checker for 8b/10b encoder output.
// Chains RD across LANES symbols per beat, flags sign/magnitude errors and tracks sync.
module rd_monitor #(
  parameter int SYM_W     = 10,
  parameter int LANES     = 1,
  parameter int CNT_W     = 16,
  parameter int ERR_LIMIT = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   startin,
  input  logic                   cnt_clr,
  input  logic [LANES*SYM_W-1:0] dataout,
  input  logic                   pushout,
  output logic                   RDout,
  output logic                   rd_locked,
  output logic                   disp_err,
  output logic [LANES-1:0]       err_lanes,
  output logic [CNT_W-1:0]       err_count,
  output logic                   sync_lost
);

  localparam int OW    = $clog2(SYM_W + 1);
  localparam int NW    = $clog2(LANES + 1);
  localparam int SUM_W = ((CNT_W > NW) ? CNT_W : NW) + 1;

  localparam logic [OW-1:0] HALF   = OW'(SYM_W / 2);
  localparam logic [OW-1:0] HALF_P = OW'(SYM_W / 2 + 1);
  localparam logic [OW-1:0] HALF_N = OW'(SYM_W / 2 - 1);

  localparam logic [7:0] LIMIT = 8'(ERR_LIMIT);
  localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});

  localparam logic [0:0] UNSYNC = 1'b0;
  localparam logic [0:0] SYNC   = 1'b1;

  logic [0:0]       state;
  logic [7:0]       consec;
  logic             rd_next;
  logic             sync_next;
  logic [LANES-1:0] mask;
  logic [NW-1:0]    err_num;
  logic [SUM_W-1:0] sum;

  // Lane chain: each lane sees the RD and sync status left by the previous lane.
  always_comb begin
    logic [SYM_W-1:0] sym;
    logic [OW-1:0]    ones;
    logic             pos;
    logic             neg;
    logic             zero;
    rd_next   = RDout;
    sync_next = (state == SYNC);
    mask      = '0;
    err_num   = '0;
    sym       = '0;
    ones      = '0;
    pos       = 1'b0;
    neg       = 1'b0;
    zero      = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      sym  = dataout[k*SYM_W +: SYM_W];
      ones = '0;
      for (int b = 0; b < SYM_W; b++) begin
        ones = ones + OW'(sym[b]);
      end
      pos  = (ones == HALF_P);
      neg  = (ones == HALF_N);
      zero = (ones == HALF);
      if (!sync_next) begin
        if (pos || neg) begin
          rd_next   = pos;
          sync_next = 1'b1;
        end
      end else if (!(pos || neg || zero)) begin
        mask[k] = 1'b1;
      end else if (pos || neg) begin
        // A disparity matching the current RD is a sign error; RD snaps to sign(d) either way.
        if (pos == rd_next) begin
          mask[k] = 1'b1;
        end
        rd_next = pos;
      end
    end
    for (int k = 0; k < LANES; k++) begin
      err_num = err_num + NW'(mask[k]);
    end
  end

  always_comb begin
    sum = (cnt_clr ? '0 : SUM_W'(err_count)) + SUM_W'(err_num);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= UNSYNC;
      consec    <= '0;
      RDout     <= 1'b0;
      disp_err  <= 1'b0;
      err_lanes <= '0;
      err_count <= '0;
      sync_lost <= 1'b0;
    end else begin
      disp_err  <= 1'b0;
      err_lanes <= '0;
      sync_lost <= 1'b0;
      if (cnt_clr) begin
        err_count <= '0;
      end
      if (startin) begin
        state  <= SYNC;
        RDout  <= 1'b0;
        consec <= '0;
      end else if (pushout) begin
        RDout     <= rd_next;
        state     <= sync_next ? SYNC : UNSYNC;
        disp_err  <= |mask;
        err_lanes <= mask;
        err_count <= (sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : sum[CNT_W-1:0];
        if (|mask) begin
          if (consec + 8'd1 >= LIMIT) begin
            state     <= UNSYNC;
            sync_lost <= 1'b1;
            consec    <= '0;
          end else begin
            consec <= consec + 8'd1;
          end
        end else if (sync_next) begin
          consec <= '0;
        end
      end
    end
  end

  assign rd_locked = (state == SYNC);

endmodule

// File: tb/tb_rd_monitor.sv
// Directed bench for rd_monitor with four 10-bit lanes and a 4-bit error counter.
// Single-lane cases pad the unused lanes with balanced (d = 0) symbols.
module tb_rd_monitor;

  localparam int SYM_W = 10;
  localparam int LANES = 4;
  localparam int CNT_W = 4;

  localparam logic [9:0] P = 10'b1111110000;
  localparam logic [9:0] N = 10'b1111000000;
  localparam logic [9:0] Z = 10'b1111100000;
  localparam logic [9:0] M = 10'b1111111000;

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic                   startin = 1'b0;
  logic                   cnt_clr = 1'b0;
  logic [LANES*SYM_W-1:0] dataout = '0;
  logic                   pushout = 1'b0;
  logic                   RDout;
  logic                   rd_locked;
  logic                   disp_err;
  logic [LANES-1:0]       err_lanes;
  logic [CNT_W-1:0]       err_count;
  logic                   sync_lost;

  int checks = 0;
  int errors = 0;

  rd_monitor #(.SYM_W(SYM_W), .LANES(LANES), .CNT_W(CNT_W), .ERR_LIMIT(4)) dut (
    .clk(clk), .reset(reset), .startin(startin), .cnt_clr(cnt_clr),
    .dataout(dataout), .pushout(pushout), .RDout(RDout), .rd_locked(rd_locked),
    .disp_err(disp_err), .err_lanes(err_lanes), .err_count(err_count),
    .sync_lost(sync_lost)
  );

  always #5 clk = ~clk;

  // Drives one cycle of inputs, waits past the edge, then returns inputs to idle.
  task automatic apply_stimulus(input logic st, input logic clr, input logic push,
                                input logic [9:0] l3, input logic [9:0] l2,
                                input logic [9:0] l1, input logic [9:0] l0);
    startin = st;
    cnt_clr = clr;
    pushout = push;
    dataout = {l3, l2, l1, l0};
    @(posedge clk);
    #1;
    startin = 1'b0;
    cnt_clr = 1'b0;
    pushout = 1'b0;
    dataout = {M, M, M, M};
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic rd, input logic lk, input logic de,
                           input logic [3:0] el, input logic [3:0] ec, input logic sl);
    check_output({tag, ".RDout"}, 32'(RDout), 32'(rd));
    check_output({tag, ".rd_locked"}, 32'(rd_locked), 32'(lk));
    check_output({tag, ".disp_err"}, 32'(disp_err), 32'(de));
    check_output({tag, ".err_lanes"}, 32'(err_lanes), 32'(el));
    check_output({tag, ".err_count"}, 32'(err_count), 32'(ec));
    check_output({tag, ".sync_lost"}, 32'(sync_lost), 32'(sl));
  endtask

  initial begin
    $display("[TB] start");
    reset = 1'b1;
    dataout = {M, M, M, M};
    pushout = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    pushout = 1'b0;
    check_all("reset", 1'b0, 1'b0, 1'b0, 4'h0, 4'd0, 1'b0);
    reset = 1'b0;

    // Acquisition from UNSYNC
    apply_stimulus(1'b0, 1'b0, 1'b1, Z, Z, Z, P);
    check_all("acq1", 1'b1, 1'b1, 1'b0, 4'h0, 4'd0, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b1, Z, Z, Z, N);
    check_all("acq2", 1'b0, 1'b1, 1'b0, 4'h0, 4'd0, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b1, Z, Z, Z, Z);
    check_all("acq3", 1'b0, 1'b1, 1'b0, 4'h0, 4'd0, 1'b0);

    // Sign error after resync
    apply_stimulus(1'b1, 1'b0, 1'b0, Z, Z, Z, Z);
    check_all("start", 1'b0, 1'b1, 1'b0, 4'h0, 4'd0, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b1, Z, Z, Z, P);
    check_all("sign1", 1'b1, 1'b1, 1'b0, 4'h0, 4'd0, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b1, Z, Z, Z, P);
    check_all("sign2", 1'b1, 1'b1, 1'b1, 4'h1, 4'd1, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b0, Z, Z, Z, M);
    check_all("idle", 1'b1, 1'b1, 1'b0, 4'h0, 4'd1, 1'b0);

    // Magnitude error with RD negative
    apply_stimulus(1'b0, 1'b0, 1'b1, Z, Z, Z, N);
    check_all("toneg", 1'b0, 1'b1, 1'b0, 4'h0, 4'd1, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b1, Z, Z, Z, M);
    check_all("mag", 1'b0, 1'b1, 1'b1, 4'h1, 4'd2, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b1, Z, Z, Z, Z);

    // Lane chain: +2, 0, +2, -2 starting from RD negative
    apply_stimulus(1'b0, 1'b0, 1'b1, N, P, Z, P);
    check_all("chain", 1'b0, 1'b1, 1'b1, 4'b0100, 4'd3, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b1, Z, Z, Z, Z);

    // Four consecutive errored beats drop sync
    apply_stimulus(1'b0, 1'b0, 1'b1, Z, Z, Z, M);
    check_all("los1", 1'b0, 1'b1, 1'b1, 4'h1, 4'd4, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b1, M, M, M, M);
    check_all("los2", 1'b0, 1'b1, 1'b1, 4'hF, 4'd8, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b1, Z, Z, Z, M);
    check_all("los3", 1'b0, 1'b1, 1'b1, 4'h1, 4'd9, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b1, Z, Z, Z, M);
    check_all("los4", 1'b0, 1'b0, 1'b1, 4'h1, 4'd10, 1'b1);
    apply_stimulus(1'b0, 1'b0, 1'b1, Z, Z, Z, M);
    check_all("los5", 1'b0, 1'b0, 1'b0, 4'h0, 4'd10, 1'b0);

    // Reacquire on lane 0; lane 3 is then checked with SYNC rules
    apply_stimulus(1'b0, 1'b0, 1'b1, P, P, Z, N);
    check_all("reacq", 1'b1, 1'b1, 1'b1, 4'b1000, 4'd11, 1'b0);

    // Clear coinciding with an errored beat keeps that beat's errors
    apply_stimulus(1'b0, 1'b1, 1'b1, Z, Z, M, M);
    check_all("clrerr", 1'b1, 1'b1, 1'b1, 4'b0011, 4'd2, 1'b0);
    apply_stimulus(1'b0, 1'b1, 1'b0, Z, Z, Z, Z);
    check_output("clr.err_count", 32'(err_count), 32'd0);
    apply_stimulus(1'b0, 1'b0, 1'b1, Z, Z, Z, Z);

    // Saturation: 20 errors, clean beats in between keep sync
    apply_stimulus(1'b0, 1'b0, 1'b1, M, M, M, M);
    apply_stimulus(1'b0, 1'b0, 1'b1, Z, Z, Z, Z);
    apply_stimulus(1'b0, 1'b0, 1'b1, M, M, M, M);
    apply_stimulus(1'b0, 1'b0, 1'b1, Z, Z, Z, Z);
    apply_stimulus(1'b0, 1'b0, 1'b1, M, M, M, M);
    check_output("sat3.err_count", 32'(err_count), 32'd12);
    apply_stimulus(1'b0, 1'b0, 1'b1, Z, Z, Z, Z);
    apply_stimulus(1'b0, 1'b0, 1'b1, M, M, M, M);
    check_all("sat4", 1'b1, 1'b1, 1'b1, 4'hF, 4'd15, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b1, Z, Z, Z, Z);
    apply_stimulus(1'b0, 1'b0, 1'b1, M, M, M, M);
    check_all("sat5", 1'b1, 1'b1, 1'b1, 4'hF, 4'd15, 1'b0);

    // startin wins over a bad beat in the same cycle
    apply_stimulus(1'b1, 1'b0, 1'b1, M, M, M, M);
    check_all("prio", 1'b0, 1'b1, 1'b0, 4'h0, 4'd15, 1'b0);

    // Reset mid-stream drops the beat in flight
    reset = 1'b1;
    apply_stimulus(1'b0, 1'b0, 1'b1, Z, Z, Z, P);
    reset = 1'b0;
    check_all("midrst", 1'b0, 1'b0, 1'b0, 4'h0, 4'd0, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b0, Z, Z, Z, P);
    check_all("postrst", 1'b0, 1'b0, 1'b0, 4'h0, 4'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
